cic_dec_rt: RTL and testbench
=============================

CIC_DEC_RT -- requirements
Module: cic_dec_rt

Interface
REQ-001 Parameter RMAX, default 64: maximum decimation rate.
REQ-002 Parameter M, default 1: differential delay; legal values are 1 and 2.
REQ-003 Parameter N, default 3: number of integrator stages and number of comb stages.
REQ-004 Parameter BIN, default 10: input width.
REQ-005 Parameter COUT, default 16: dout_cut width.
REQ-006 Parameter BOUT, default 28: full-precision width; SHALL equal BIN + ceil(N*log2(RMAX*M)), computed by the instantiator.
REQ-007 Parameter RW = $clog2(RMAX+1), SW = $clog2(BOUT-COUT+1): derived, not overridden.
REQ-008 Clock: clk, input, 1 bit; single clock; all logic on its rising edge.
REQ-009 Reset: rst_n, input, 1 bit; asynchronous, active-low.
REQ-010 din_vld  input  1  input sample strobe.
REQ-011 din  input  BIN  signed two's-complement sample.
REQ-012 dec_rate  input  RW  requested decimation rate, sampled on rate_load.
REQ-013 rate_load  input  1  one-cycle pulse; loads dec_rate and flushes the filter.
REQ-014 cut_sh  input  SW  output window shift, static or changed only between outputs.
REQ-015 dout  output  BOUT  signed full-precision output.
REQ-016 dout_cut  output  COUT  scaled output window.
REQ-017 dval  output  1  one-cycle valid for dout and dout_cut.
REQ-018 busy  output  1  high while the comb engine is running.

Function
REQ-019 Integrators SHALL update only in cycles with din_vld=1; all arithmetic SHALL be sign-extended to BOUT and wrap modulo 2^BOUT.
REQ-020 The sample counter SHALL count accepted samples; on the accepted sample where count = rate-1, the final-integrator sum including that sample SHALL be captured, the counter SHALL clear, and the comb engine SHALL start.
REQ-021 Comb engine: a single shared BOUT-bit subtractor with FSM states IDLE, COMB, OUT; busy=1 in COMB and OUT.
REQ-022 COMB SHALL run N cycles; stage k computes acc <= acc - dly[k][M-1] and shifts the stage-k delay line (depth M) with the stage-k input.
REQ-023 OUT SHALL register dout and dout_cut, pulse dval for one cycle, and return to IDLE.
REQ-024 dval SHALL assert exactly N+1 cycles after the capturing clock edge.
REQ-025 Effective rate = clamp(dec_rate, max(2, N+1), RMAX); this guarantees the engine finishes before the next capture.
REQ-026 On rate_load: load the clamped rate; zero the integrators, comb delay lines and counter; abort the FSM to IDLE with no dval. A din_vld in the same cycle SHALL be discarded.
REQ-027 dout_cut SHALL be dout[BOUT-1-s : BOUT-COUT-s], where s = min(cut_sh, BOUT-COUT).
REQ-028 dout and dout_cut SHALL hold their values between dval pulses.

Reset
REQ-029 When rst_n=0: integrators, delay lines, counter, acc, dout, dout_cut, dval and busy SHALL be 0, FSM SHALL be IDLE, and the rate register SHALL be RMAX.
REQ-030 Reset asserted mid-COMB SHALL abort the FSM; no dval SHALL be produced for the aborted output.

Configuration
REQ-031 Macro CIC_DEC_ROUND_EN defined: dout_cut SHALL be rounded half-up by adding the bit just below the window LSB (only when s < BOUT-COUT), saturating at +2^(COUT-1)-1.
REQ-032 Macro CIC_DEC_ROUND_EN undefined: dout_cut SHALL be plain truncation (floor).

Verification (N=3, M=1, BIN=10, RMAX=64, COUT=16, BOUT=28)
REQ-033 din=1 constant, din_vld=1, rate=8 -> dval every 8 cycles; dout=512 from the 3rd output onward.
REQ-034 din=-512 constant, rate=64, cut_sh=0 -> steady dout=-134217728, dout_cut=-32768; no wrap.
REQ-035 din_vld high every other cycle, din=1, rate=8 -> dval period 16 cycles; dout=512 steady.
REQ-036 rate_load with dec_rate=1 while busy=1 -> rate clamps to 4, no dval for the aborted output, first new dval after 4 accepted samples + 4 cycles.
REQ-037 din=4 constant, rate=8, cut_sh=0 -> dout=2048; dout_cut=1 with CIC_DEC_ROUND_EN, 0 without.
REQ-038 rst_n pulsed low during COMB -> all outputs 0 immediately; no dval until a full new decimation period completes.

Source files
------------

// File: rtl/cic_dec_rt_if.sv
// Handshake and data bundle for the runtime-rate CIC decimator.
// Master drives samples and controls; slave returns filter outputs.
interface cic_dec_rt_if #(
    parameter int BIN  = 10,
    parameter int COUT = 16,
    parameter int BOUT = 28,
    parameter int RW   = 7,
    parameter int SW   = 4
);
    logic            din_vld;
    logic [BIN-1:0]  din;
    logic [RW-1:0]   dec_rate;
    logic            rate_load;
    logic [SW-1:0]   cut_sh;
    logic [BOUT-1:0] dout;
    logic [COUT-1:0] dout_cut;
    logic            dval;
    logic            busy;

    modport master (
        output din_vld, din, dec_rate, rate_load, cut_sh,
        input  dout, dout_cut, dval, busy
    );

    modport slave (
        input  din_vld, din, dec_rate, rate_load, cut_sh,
        output dout, dout_cut, dval, busy
    );
endinterface

// File: rtl/cic_dec_rt.sv
// CIC decimator, runtime rate, single shared comb subtractor.
// Define CIC_DEC_ROUND_EN for round-half-up on dout_cut (else truncation).
module cic_dec_rt #(
    parameter int RMAX = 64,
    parameter int M    = 1,
    parameter int N    = 3,
    parameter int BIN  = 10,
    parameter int COUT = 16,
    parameter int BOUT = 28
) (
    input logic        clk,
    input logic        rst_n,
    cic_dec_rt_if.slave bus
);
    localparam int RW  = $clog2(RMAX + 1);
    localparam int SW  = $clog2(BOUT - COUT + 1);
    localparam int RLO = (N + 1 > 2) ? N + 1 : 2;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = BOUT - COUT;

    typedef enum logic [1:0] {IDLE, COMB, OUT} state_t;

    logic [BOUT-1:0] integ [N];
    logic [BOUT-1:0] isum  [N];
    logic [BOUT-1:0] dly   [N][M];
    logic [BOUT-1:0] acc;
    logic [RW-1:0]   rate;
    logic [RW-1:0]   cnt;
    logic [RW-1:0]   rate_cl;
    logic [KW-1:0]   stg;
    logic [SW-1:0]   s_cl;
    logic [SW-1:0]   sh;
    logic [COUT-1:0] win;
    logic [COUT-1:0] cut_nxt;
    logic            take;
    logic            cap;
    state_t          state;

    // Integrator chain sees the current sample, so the capture includes it.
    always_comb begin
        isum[0] = integ[0] + {{(BOUT-BIN){bus.din[BIN-1]}}, bus.din};
        for (int k = 1; k < N; k++) begin
            isum[k] = integ[k] + isum[k-1];
        end
    end

    always_comb begin
        if (bus.dec_rate < RW'(RLO)) begin
            rate_cl = RW'(RLO);
        end else if (bus.dec_rate > RW'(RMAX)) begin
            rate_cl = RW'(RMAX);
        end else begin
            rate_cl = bus.dec_rate;
        end
    end

    assign take = bus.din_vld && !bus.rate_load;
    assign cap  = take && (cnt == rate - 1'b1);

    always_comb begin
        s_cl = (bus.cut_sh > SW'(CW)) ? SW'(CW) : bus.cut_sh;
        sh   = SW'(CW) - s_cl;
        win  = COUT'(acc >> sh);
    end

`ifdef CIC_DEC_ROUND_EN
    logic rb;
    always_comb begin
        rb = (sh != '0) & 1'(acc >> (sh - 1'b1));
        if (rb && win != {1'b0, {(COUT-1){1'b1}}}) begin
            cut_nxt = win + 1'b1;
        end else begin
            cut_nxt = win;
        end
    end
`else
    always_comb begin
        cut_nxt = win;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate <= RW'(RMAX);
            cnt  <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (bus.rate_load) begin
            rate <= rate_cl;
            cnt  <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (take) begin
            cnt <= cap ? '0 : cnt + 1'b1;
            for (int k = 0; k < N; k++) begin
                integ[k] <= isum[k];
            end
        end
    end

    // A capture may land on the OUT cycle; OUT still emits, capture restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            stg          <= '0;
            bus.dout     <= '0;
            bus.dout_cut <= '0;
            bus.dval     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < M; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else begin
            bus.dval <= 1'b0;
            if (bus.rate_load) begin
                state <= IDLE;
                acc   <= '0;
                stg   <= '0;
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < M; j++) begin
                        dly[k][j] <= '0;
                    end
                end
            end else begin
                unique case (state)
                    COMB: begin
                        acc         <= acc - dly[stg][M-1];
                        dly[stg][0] <= acc;
                        for (int j = M - 1; j > 0; j--) begin
                            dly[stg][j] <= dly[stg][j-1];
                        end
                        stg <= stg + 1'b1;
                        if (stg == KW'(N - 1)) begin
                            state <= OUT;
                        end
                    end
                    OUT: begin
                        bus.dout     <= acc;
                        bus.dout_cut <= cut_nxt;
                        bus.dval     <= 1'b1;
                        state        <= IDLE;
                    end
                    default: begin
                    end
                endcase
                if (cap) begin
                    state <= COMB;
                    acc   <= isum[N-1];
                    stg   <= '0;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_cic_dec_rt.sv
// Directed and random checks of cic_dec_rt against a closed-form CIC model.
// Integrator and comb responses are computed with binomial sums.
module tb_cic_dec_rt;
    localparam int N    = 3;
    localparam int M    = 1;
    localparam int BIN  = 10;
    localparam int COUT = 16;
    localparam int BOUT = 28;
    localparam int RMAX = 64;
    localparam int RW   = 7;
    localparam int SW   = 4;
    localparam int CW   = BOUT - COUT;
`ifdef CIC_DEC_ROUND_EN
    localparam int EXP_CUT4 = 1;
`else
    localparam int EXP_CUT4 = 0;
`endif

    typedef struct {
        int     due;
        longint y;
    } pend_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   e;
    int   csh;
    int   mrate;
    int   mcnt;
    longint samp[$];
    longint caps[$];
    pend_t  pend[$];
    longint last_y;
    longint last_cut;

    cic_dec_rt_if #(
        .BIN(BIN), .COUT(COUT), .BOUT(BOUT), .RW(RW), .SW(SW)
    ) bus ();

    cic_dec_rt #(
        .RMAX(RMAX), .M(M), .N(N),
        .BIN(BIN), .COUT(COUT), .BOUT(BOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint binom(int n, int k);
        longint r = 1;
        if (k < 0 || n < k) return 0;
        for (int i = 1; i <= k; i++) begin
            r = r * (n - k + i) / i;
        end
        return r;
    endfunction

    function automatic longint sxw(longint v, int w);
        longint m = (longint'(1) <<< w) - 1;
        longint r = v & m;
        if (r >= (longint'(1) <<< (w - 1))) r = r - (longint'(1) <<< w);
        return r;
    endfunction

    function automatic longint cut_model(longint y, int c);
        int     s  = (c > CW) ? CW : c;
        int     sh = CW - s;
        longint t  = sxw(y >>> sh, COUT);
`ifdef CIC_DEC_ROUND_EN
        if (sh > 0) begin
            longint r = sxw((y + (longint'(1) <<< (sh - 1))) >>> sh, COUT);
            if (t != (longint'(1) <<< (COUT - 1)) - 1) t = r;
        end
`endif
        return t;
    endfunction

    task automatic chk(string tag, logic signed [63:0] obs,
                       logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(int r);
        mrate = r;
        mcnt  = 0;
        samp.delete();
        caps.delete();
        pend.delete();
    endtask

    task automatic model_sample(longint x);
        longint c;
        longint y;
        int     n;
        int     l;
        samp.push_back(x);
        mcnt++;
        if (mcnt == mrate) begin
            mcnt = 0;
            n = samp.size() - 1;
            c = 0;
            for (int m = 0; m <= n; m++) begin
                c += binom(n - m + N - 1, N - 1) * samp[m];
            end
            caps.push_back(sxw(c, BOUT));
            l = caps.size() - 1;
            y = 0;
            for (int i = 0; i <= N; i++) begin
                if (l - i * M >= 0) begin
                    y += ((i % 2) ? -1 : 1) * binom(N, i) * caps[l - i * M];
                end
            end
            pend.push_back('{e + N + 1, sxw(y, BOUT)});
        end
    endtask

    task automatic check_cycle();
        bit ev;
        ev = (pend.size() > 0) && (pend[0].due == e);
        chk("dval", bus.dval, ev);
        if (ev) begin
            last_y   = pend.pop_front().y;
            last_cut = cut_model(last_y, csh);
        end
        chk("dout", $signed(bus.dout), last_y);
        chk("dout_cut", $signed(bus.dout_cut), last_cut);
    endtask

    task automatic step(input bit vld, input int x,
                        input bit ld, input int rv);
        int r;
        bus.din_vld   = vld;
        bus.din       = BIN'(x);
        bus.rate_load = ld;
        bus.dec_rate  = RW'(rv);
        bus.cut_sh    = SW'(csh);
        @(posedge clk);
        e++;
        if (ld) begin
            r = rv % 128;
            r = (r < N + 1) ? N + 1 : ((r > RMAX) ? RMAX : r);
            model_clear(r);
        end else if (vld) begin
            model_sample(longint'(x));
        end
        #1;
        check_cycle();
    endtask

    initial begin
        int  el;
        int  lat;
        int  nd;
        bit  got;
        n_cmp = 0;
        n_bad = 0;
        e     = 0;
        csh   = 0;
        last_y   = 0;
        last_cut = 0;
        model_clear(RMAX);
        rst_n         = 1'b0;
        bus.din_vld   = 1'b0;
        bus.din       = '0;
        bus.rate_load = 1'b0;
        bus.dec_rate  = '0;
        bus.cut_sh    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", $signed(bus.dout), 0);
        chk("rst_cut", $signed(bus.dout_cut), 0);
        chk("rst_dval", bus.dval, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // constant ones, rate 8
        step(0, 0, 1, 8);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
        chk("ones_r8", $signed(bus.dout), 512);

        // every other sample
        step(0, 0, 1, 8);
        for (int i = 0; i < 90; i++) step(i % 2 == 0, 1, 0, 0);
        chk("half_vld", $signed(bus.dout), 512);

        // full-scale negative at max rate
        csh = 0;
        step(0, 0, 1, 64);
        for (int i = 0; i < 64 * 3 + 8; i++) step(1, -512, 0, 0);
        chk("neg_full", $signed(bus.dout), -134217728);
        chk("neg_cut", $signed(bus.dout_cut), -32768);

        // rounding edge
        step(0, 0, 1, 8);
        for (int i = 0; i < 40; i++) step(1, 4, 0, 0);
        chk("four_dout", $signed(bus.dout), 2048);
        chk("four_cut", $signed(bus.dout_cut), EXP_CUT4);

        // random phases
        for (int p = 0; p < 6; p++) begin
            csh = $urandom_range(0, 15);
            step(0, 0, 1, $urandom_range(0, 127));
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 1023)) - 512, 0, 0);
            end
        end
        csh = 0;

        // reload with clamped rate while busy
        step(0, 0, 1, 8);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1, 1, 0, 0);
            got = bus.busy;
        end
        chk("busy_seen", got, 1);
        step(1, 1, 1, 1);
        el  = e;
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step(1, 1, 0, 0);
            if (bus.dval) lat = e - el;
        end
        chk("reload_lat", lat, 8);

        // reset in the middle of the comb pass
        step(0, 0, 1, 8);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1, 1, 0, 0);
            got = bus.busy;
        end
        chk("busy_seen2", got, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_dout", $signed(bus.dout), 0);
        chk("mid_cut", $signed(bus.dout_cut), 0);
        chk("mid_dval", bus.dval, 0);
        chk("mid_busy", bus.busy, 0);
        model_clear(RMAX);
        last_y   = 0;
        last_cut = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nd = 0;
        for (int i = 0; i < 72; i++) begin
            step(1, 1, 0, 0);
            nd += int'(bus.dval);
        end
        chk("post_rst_dvals", nd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
